// File: rtl/onehot_run_detector.sv
// One-hot Moore FSM that flags a run of RUN_LEN equal samples (all-0 or all-1) on w.
// It also provides run length, a saturating match counter and recovery from illegal states.
module onehot_run_detector #(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned NS      = 2 * RUN_LEN + 1,
  parameter int unsigned LW      = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic             mode,
  output logic             z,
  output logic             zero_run,
  output logic             one_run,
  output logic [LW-1:0]    run_len,
  output logic [NS-1:0]    state,
  output logic             state_err,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned ZN = RUN_LEN;
  localparam int unsigned O1 = RUN_LEN + 1;
  localparam int unsigned ON = 2 * RUN_LEN;
  localparam logic [NS-1:0] StIdle = {{(NS - 1){1'b0}}, 1'b1};

  logic [NS-1:0]    state_q, state_d, step_st;
  logic [CNT_W-1:0] count_q, count_d;
  logic             any_z, any_o, completes;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    step_st = '0;
    any_z   = |state_q[ZN:1];
    any_o   = |state_q[ON:O1];

    step_st[1] = ~w & (state_q[0] | any_o | (state_q[ZN] & mode));
    for (int k = 2; k < int'(RUN_LEN); k++) begin
      step_st[k] = ~w & state_q[k-1];
    end
    step_st[ZN] = ~w & (state_q[ZN-1] | (state_q[ZN] & ~mode));

    step_st[O1] = w & (state_q[0] | any_z | (state_q[ON] & mode));
    for (int k = 2; k < int'(RUN_LEN); k++) begin
      step_st[RUN_LEN+k] = w & state_q[RUN_LEN+k-1];
    end
    step_st[ON] = w & (state_q[ON-1] | (state_q[ON] & ~mode));

    if (state_err) begin
      state_d = StIdle;
    end else if (en) begin
      state_d = step_st;
    end else begin
      state_d = state_q;
    end

    // Only entering a full-run state counts; the saturating self-loop does not.
    completes = en & ~state_err &
                ((step_st[ZN] & ~state_q[ZN]) | (step_st[ON] & ~state_q[ON]));
    if (completes && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // Output decode
  always_comb begin
    state_err = ($countones(state_q) != 1);
    run_len   = '0;
    for (int k = 1; k <= int'(RUN_LEN); k++) begin
      if (state_q[k] || state_q[RUN_LEN+k]) begin
        run_len = run_len | LW'(k);
      end
    end
    if (state_err) begin
      run_len = '0;
    end
    zero_run    = state_q[ZN] & ~state_err;
    one_run     = state_q[ON] & ~state_err;
    z           = zero_run | one_run;
    state       = state_q;
    match_count = count_q;
  end

endmodule

// File: tb/tb_onehot_run_detector.sv
// Randomised scoreboard bench for onehot_run_detector against a run-length reference model.
module tb_onehot_run_detector;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 3;
  localparam int unsigned NS = 2 * N + 1;
  localparam int unsigned LW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          w = 1'b0;
  logic          mode = 1'b0;
  logic          z, zero_run, one_run, state_err;
  logic [LW-1:0] run_len;
  logic [NS-1:0] state;
  logic [CW-1:0] match_count;

  onehot_run_detector #(.RUN_LEN(N), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .w           (w),
    .mode        (mode),
    .z           (z),
    .zero_run    (zero_run),
    .one_run     (one_run),
    .run_len     (run_len),
    .state       (state),
    .state_err   (state_err),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] st;
    logic [LW-1:0] rl;
    logic [CW-1:0] mc;
    logic          zz;
    logic          zr;
    logic          orr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: direction of the current run, its length, detections so far.
  bit m_idle = 1'b1;
  bit m_dir  = 1'b0;
  int m_len  = 0;
  int m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.st = '0;
    if (m_idle) e.st[0] = 1'b1;
    else e.st[m_dir ? N + m_len : m_len] = 1'b1;
    e.rl  = LW'(m_len);
    e.mc  = CW'(m_cnt);
    e.zz  = (m_len == N);
    e.zr  = (m_len == N) && !m_dir;
    e.orr = (m_len == N) && m_dir;
    return e;
  endfunction

  task automatic drive(input bit r, input bit e, input bit wi, input bit mi);
    int old_len;
    bit old_dir;
    @(negedge clk);
    reset = r; en = e; w = wi; mode = mi;
    if (!r) begin
      m_idle = 1'b1; m_dir = 1'b0; m_len = 0; m_cnt = 0;
    end else if (e) begin
      old_len = m_len;
      old_dir = m_dir;
      if (m_idle || wi != m_dir) begin
        m_idle = 1'b0; m_dir = wi; m_len = 1;
      end else if (m_len < N) begin
        m_len++;
      end else if (mi) begin
        m_len = 1;
      end
      if (m_len == N && !(old_len == N && old_dir == m_dir) && m_cnt < (1 << CW) - 1)
        m_cnt++;
    end
    exp_q.push_back(model_expect());
  endtask

  // Monitor: every clock edge presents a new output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("z", 32'(z), 32'(e.zz));
        chk("zero_run", 32'(zero_run), 32'(e.zr));
        chk("one_run", 32'(one_run), 32'(e.orr));
        chk("run_len", 32'(run_len), 32'(e.rl));
        chk("state_err", 32'(state_err), 32'(0));
        chk("match_count", 32'(match_count), 32'(e.mc));
      end
    end
  end

  initial begin
    bit wr;
    // Reset with w toggling
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 1);
    // Zero run, saturate, then switch direction
    for (int i = 0; i < 7; i++) drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    // Restart mode on a one run
    for (int i = 0; i < 7; i++) drive(1, 1, 1, 1);
    // Enable gating at Z_2
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 0);
    drive(1, 1, 0, 0);
    // Alternating input never completes a run
    for (int i = 0; i < 20; i++) drive(1, 1, 1'(i % 2), 0);
    // Reset mid-run at O_2
    drive(1, 1, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 1, 1, 0);
    // Long restart run drives the counter into saturation
    for (int i = 0; i < 36; i++) drive(1, 1, 1, 1);
    // Randomised traffic with occasional resets
    wr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 30) wr = ~wr;
      drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
            wr, 1'($urandom_range(0, 1)));
    end
    drive(1, 1, 0, 0);

    // Illegal state: wait until the scoreboard has drained, then corrupt the register.
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    en = 1'b0;
    force dut.state_q = 7'b0000110;
    #1;
    chk("err_flag", 32'(state_err), 32'(1));
    chk("err_z", 32'(z), 32'(0));
    chk("err_zero_run", 32'(zero_run), 32'(0));
    chk("err_run_len", 32'(run_len), 32'(0));
    release dut.state_q;
    @(posedge clk);
    #1;
    chk("recover_state", 32'(state), 32'(1));
    chk("recover_err", 32'(state_err), 32'(0));
    chk("recover_count", 32'(match_count), 32'(m_cnt));
    m_idle = 1'b1; m_len = 0; m_dir = 1'b0;
    // Normal operation resumes from IDLE
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
